// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS datapath blocks.
// Holds the extension-mode encodings driven by the control unit's ExtSrc
// line, the default immediate and word widths, and the datapath word type.
package cpu_pkg;

  // ExtSrc encodings
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  // Default widths of the instruction immediate field and a datapath word
  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/sign_zero_extender_ext_core.sv
// ext_core: purely combinational immediate extension.
// Ports:
//   ExtSrc    in   extension mode (EXT_ZERO / EXT_SIGN)
//   Immediate in   IMM_W-bit instruction immediate
//   ImExtend  out  OUT_W-bit extended result
// The low IMM_W bits always pass Immediate through untouched; only the
// fill bits above them depend on the mode.
module ext_core #(
  parameter int IMM_W = cpu_pkg::IMM_W,
  parameter int OUT_W = cpu_pkg::WORD_W
) (
  input  logic             ExtSrc,
  input  logic [IMM_W-1:0] Immediate,
  output logic [OUT_W-1:0] ImExtend
);

  logic fillBit;

  // The fill bit is the immediate's MSB in sign mode and zero otherwise.
  assign fillBit  = (ExtSrc == cpu_pkg::EXT_SIGN) ? Immediate[IMM_W-1] : 1'b0;
  assign ImExtend = {{(OUT_W-IMM_W){fillBit}}, Immediate};

endmodule

// File: rtl/sign_zero_extender.sv
// sign_zero_extender: immediate-extension unit for the MIPS datapath.
// Produces a zero- or sign-extended operand combinationally for same-cycle
// use, plus a registered copy with a valid flag for pipelined or multi-cycle
// consumers. OUT_W must be greater than IMM_W.
// Ports:
//   CLK        in   system clock, rising-edge active
//   RST_n      in   asynchronous active-low reset
//   ExtSrc     in   0 = zero-extend, 1 = sign-extend
//   Immediate  in   IMM_W-bit instruction immediate
//   in_valid   in   capture enable for the registered path
//   ImExtend   out  combinational extended result (not gated by reset)
//   ImExtend_q out  registered extended result
//   out_valid  out  ImExtend_q was captured on the most recent edge
module sign_zero_extender #(
  parameter int IMM_W = cpu_pkg::IMM_W,
  parameter int OUT_W = cpu_pkg::WORD_W
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             ExtSrc,
  input  logic [IMM_W-1:0] Immediate,
  input  logic             in_valid,
  output logic [OUT_W-1:0] ImExtend,
  output logic [OUT_W-1:0] ImExtend_q,
  output logic             out_valid
);

  logic [OUT_W-1:0] extResult;

  ext_core #(
    .IMM_W(IMM_W),
    .OUT_W(OUT_W)
  ) uExtCore (
    .ExtSrc   (ExtSrc),
    .Immediate(Immediate),
    .ImExtend (extResult)
  );

  assign ImExtend = extResult;

  // Capture register: loads on every in_valid cycle (no back-pressure) and
  // holds otherwise. The valid flag only marks the cycle after a capture,
  // so it drops even while the held data stays put. Reset clears both
  // immediately, discarding any capture in flight.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ImExtend_q <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (in_valid) begin
        ImExtend_q <= extResult;
      end
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_sign_zero_extender.sv
// Self-checking bench for sign_zero_extender.
// Combinational results are checked against a bench reference model right
// after each drive; registered results come from a scoreboard queue filled
// when a capture is requested and drained when out_valid is expected.
module tb_sign_zero_extender;

  logic        CLK;
  logic        RST_n;
  logic        ExtSrc;
  logic [15:0] Immediate;
  logic        in_valid;
  logic [31:0] ImExtend;
  logic [31:0] ImExtend_q;
  logic        out_valid;

  int          testCount;
  int          failCount;
  logic [31:0] expectQ[$];
  logic [31:0] heldValue;

  sign_zero_extender #(
    .IMM_W(16),
    .OUT_W(32)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .ExtSrc    (ExtSrc),
    .Immediate (Immediate),
    .in_valid  (in_valid),
    .ImExtend  (ImExtend),
    .ImExtend_q(ImExtend_q),
    .out_valid (out_valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model, written independently of the RTL structure
  function automatic logic [31:0] extendRef(input logic mode, input logic [15:0] imm);
    logic [31:0] r;
    r = {16'h0000, imm};
    if (mode && imm[15]) r = r | 32'hFFFF_0000;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge, check the combinational
  // output, then check the registered outputs just after the rising edge.
  task automatic applyStimulus(input string tag, input logic mode,
                               input logic [15:0] imm, input logic valid,
                               input logic [31:0] expComb);
    logic [31:0] expReg;
    @(negedge CLK);
    ExtSrc    = mode;
    Immediate = imm;
    in_valid  = valid;
    #1;
    checkOutput({tag, "_comb"}, ImExtend, expComb);
    if (valid) expectQ.push_back(extendRef(mode, imm));
    @(posedge CLK);
    #1;
    if (expectQ.size() > 0) begin
      expReg    = expectQ.pop_front();
      heldValue = expReg;
      checkOutput({tag, "_q"}, ImExtend_q, expReg);
      checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    end else begin
      checkOutput({tag, "_qhold"}, ImExtend_q, heldValue);
      checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    heldValue = 32'h0;
    RST_n     = 1'b0;
    ExtSrc    = 1'b0;
    Immediate = 16'h0000;
    in_valid  = 1'b1;

    // Reset held across a rising edge with in_valid high
    @(posedge CLK);
    #1;
    checkOutput("reset_q", ImExtend_q, 32'h0);
    checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;

    // Main function
    applyStimulus("zero_small", 1'b0, 16'h0007, 1'b1, 32'h0000_0007);
    applyStimulus("sign_pos",   1'b1, 16'h000A, 1'b1, 32'h0000_000A);
    applyStimulus("sign_neg",   1'b1, 16'h8007, 1'b1, 32'hFFFF_8007);
    applyStimulus("zero_neg",   1'b0, 16'h8007, 1'b1, 32'h0000_8007);

    // Boundaries
    applyStimulus("sign_7fff",  1'b1, 16'h7FFF, 1'b1, 32'h0000_7FFF);
    applyStimulus("sign_8000",  1'b1, 16'h8000, 1'b1, 32'hFFFF_8000);
    applyStimulus("zero_ffff",  1'b0, 16'hFFFF, 1'b1, 32'h0000_FFFF);

    // Hold: capture all-ones, then idle with a new immediate
    applyStimulus("cap_ffff",   1'b1, 16'hFFFF, 1'b1, 32'hFFFF_FFFF);
    applyStimulus("hold",       1'b1, 16'h1234, 1'b0, 32'h0000_1234);
    applyStimulus("hold2",      1'b0, 16'hABCD, 1'b0, 32'h0000_ABCD);

    // Asynchronous reset mid-cycle with a capture pending
    applyStimulus("pre_reset",  1'b1, 16'hC001, 1'b1, 32'hFFFF_C001);
    @(negedge CLK);
    ExtSrc    = 1'b1;
    Immediate = 16'h9000;
    in_valid  = 1'b1;
    #2;
    RST_n = 1'b0;
    #1;
    checkOutput("async_q", ImExtend_q, 32'h0);
    checkOutput("async_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async_comb", ImExtend, 32'hFFFF_9000);
    @(posedge CLK);
    #1;
    checkOutput("inreset_q", ImExtend_q, 32'h0);
    checkOutput("inreset_valid", {31'b0, out_valid}, 32'd0);
    expectQ.delete();
    heldValue = 32'h0;
    @(negedge CLK);
    RST_n = 1'b1;
    applyStimulus("post_reset", 1'b0, 16'h00FF, 1'b1, 32'h0000_00FF);

    // Exhaustive combinational sweep in both modes, register idle
    @(negedge CLK);
    in_valid = 1'b0;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 65536; i++) begin
        ExtSrc    = m[0];
        Immediate = i[15:0];
        #1;
        checkOutput(m[0] ? "sweep_sign" : "sweep_zero", ImExtend,
                    extendRef(m[0], i[15:0]));
      end
    end
    @(posedge CLK);
    #1;
    checkOutput("sweep_qhold", ImExtend_q, heldValue);
    checkOutput("sweep_valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
